// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one synchronous RAM port
// among NREQ requesters, with locked bursts of up to MAX_BURST transfers
// and a read-data-valid pipeline that returns rvalid two edges after accept.
module ram_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ-1:0]     we,
    input  logic [NREQ*AW-1:0]  addr,
    input  logic [NREQ*DW-1:0]  wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [DW-1:0]       rdata,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_data,
    output logic                ram_we,
    input  logic [DW-1:0]       ram_q
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [PW-1:0] ptr;
    logic [CW-1:0] burst_cnt;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] nxt_idx;
    logic [PW-1:0] cand;
    logic          found;

    // Read tracking: p0 is loaded with the RAM port registers, p1 one edge
    // later; rvalid is registered from p1 so it lands with the RAM output.
    logic          p0_v;
    logic [PW-1:0] p0_idx;
    logic          p1_v;
    logic [PW-1:0] p1_idx;
    logic [NREQ-1:0] rv_next;

    assign rdata = ram_q;

    // Round-robin search starting at ptr; the first requesting index wins.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        if (!rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = PW'((32'(ptr) + k) % NREQ);
                if (!found && req[cand]) begin
                    found   = 1'b1;
                    win_idx = cand;
                end
            end
            gnt[win_idx] = found;
        end
    end

    // Pointer successor of the winner and one-hot decode of the read stage.
    always_comb begin
        nxt_idx = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        rv_next = '0;
        rv_next[p1_idx] = p1_v;
    end

    // Arbitration state, RAM port registers and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            burst_cnt <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            p0_v      <= 1'b0;
            p0_idx    <= '0;
            p1_v      <= 1'b0;
            p1_idx    <= '0;
            rvalid    <= '0;
        end else begin
            p1_v   <= p0_v;
            p1_idx <= p0_idx;
            rvalid <= rv_next;
            if (found) begin
                ram_addr <= addr[win_idx*AW +: AW];
                ram_data <= wdata[win_idx*DW +: DW];
                ram_we   <= we[win_idx];
                p0_v     <= ~we[win_idx];
                p0_idx   <= win_idx;
                if (lock[win_idx]) begin
                    // Burst holds the pointer until the MAX_BURST-th locked
                    // transfer, then yields even if lock is still high.
                    if (burst_cnt == CW'(MAX_BURST - 1)) begin
                        ptr       <= nxt_idx;
                        burst_cnt <= '0;
                    end else begin
                        ptr       <= win_idx;
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    ptr       <= nxt_idx;
                    burst_cnt <= '0;
                end
            end else begin
                ram_we    <= 1'b0;
                p0_v      <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks of grant order, locked bursts,
// read latency, write-then-read forwarding through the RAM, and reset.
module tb_ram_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, lock, we;
    logic [AW-1:0]     a [NREQ];
    logic [DW-1:0]     d [NREQ];
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt, rvalid;
    logic [DW-1:0]     rdata, ram_data, ram_q;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;

    int n_checks = 0;
    int n_fail   = 0;

    assign addr  = {a[2], a[1], a[0]};
    assign wdata = {d[2], d[1], d[0]};

    ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: latches address/write at an edge, output valid one edge later.
    logic [DW-1:0] mem [64];
    logic [AW-1:0] a_r;
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
        a_r   = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        a_r   <= ram_addr;
        ram_q <= mem[a_r];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; we = '0;
        for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end

        // Reset: no grant even with requests, port registers cleared.
        tick(); tick();
        req = 3'b111; #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        check("rst_addr", 32'(ram_addr), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);

        // Round robin 0,1,2,0 with reads of 10,11,12.
        a[0] = 6'd10; a[1] = 6'd11; a[2] = 6'd12;
        rst = 1'b0; #1;
        check("rr_g0", 32'(gnt), 32'h1);
        tick();
        check("rr_addr", 32'(ram_addr), 32'd10);
        check("rr_we", 32'(ram_we), 32'h0);
        check("rr_g1", 32'(gnt), 32'h2);
        tick();
        check("rr_g2", 32'(gnt), 32'h4);
        check("rr_rv_early", 32'(rvalid), 32'h0);
        tick();
        check("rr_g3", 32'(gnt), 32'h1);
        check("rr_rv0", 32'(rvalid), 32'h1);
        check("rr_rd0", 32'(rdata), 32'd31);
        tick();
        check("rr_rv1", 32'(rvalid), 32'h2);
        check("rr_rd1", 32'(rdata), 32'd34);
        req = '0; #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        tick();
        check("rr_rv2", 32'(rvalid), 32'h4);
        check("rr_rd2", 32'(rdata), 32'd37);
        tick();
        check("rr_rv3", 32'(rvalid), 32'h1);
        check("rr_rd3", 32'(rdata), 32'd31);
        tick();
        check("rr_rv_end", 32'(rvalid), 32'h0);
        check("idle_we", 32'(ram_we), 32'h0);

        // Requester 1 writes 33 to 1, then reads it back.
        req = 3'b010; we = 3'b010; a[1] = 6'h01; d[1] = 8'h33; #1;
        check("wr_gnt", 32'(gnt), 32'h2);
        tick();
        check("wr_we", 32'(ram_we), 32'h1);
        check("wr_addr", 32'(ram_addr), 32'h01);
        check("wr_data", 32'(ram_data), 32'h33);
        we = '0; #1;
        check("rd_gnt", 32'(gnt), 32'h2);
        tick();
        check("rd_we", 32'(ram_we), 32'h0);
        req = '0;
        tick();
        check("wr_no_rv", 32'(rvalid), 32'h0);
        tick();
        check("raw_rv", 32'(rvalid), 32'h2);
        check("raw_rd", 32'(rdata), 32'h33);
        tick();
        check("raw_rv_end", 32'(rvalid), 32'h0);

        // Read by 2 then reset next edge: no rvalid, pointer back to 0.
        req = 3'b100; a[2] = 6'h02; #1;
        check("rs_gnt", 32'(gnt), 32'h4);
        tick();
        rst = 1'b1; #1;
        check("rs_gnt_rst", 32'(gnt), 32'h0);
        tick();
        check("rs_rv0", 32'(rvalid), 32'h0);
        check("rs_addr", 32'(ram_addr), 32'h0);
        tick();
        check("rs_rv1", 32'(rvalid), 32'h0);
        rst = 1'b0; req = '0;
        tick();
        check("rs_rv2", 32'(rvalid), 32'h0);

        // Locked burst by 0 (writer) against 2 (reader).
        a[0] = 6'h20; d[0] = 8'h55; we = 3'b001; lock = 3'b001; req = 3'b101; #1;
        check("rs_ptr0", 32'(gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("burst_g0", 32'(gnt), 32'h1);
            tick();
        end
        check("burst_we", 32'(ram_we), 32'h1);
        check("burst_g2", 32'(gnt), 32'h4);
        tick();
        check("burst_back0", 32'(gnt), 32'h1);
        tick();
        // Gap of three idle cycles ends the burst.
        req = '0;
        tick();
        check("gap_we", 32'(ram_we), 32'h0);
        check("gap_rv2", 32'(rvalid), 32'h4);
        check("gap_rd2", 32'(rdata), 32'd7);
        tick();
        check("gap_rv_a", 32'(rvalid), 32'h0);
        tick();
        check("gap_rv_b", 32'(rvalid), 32'h0);
        req = 3'b101; #1;
        for (int i = 0; i < 4; i++) begin
            check("reburst_g0", 32'(gnt), 32'h1);
            tick();
        end
        check("reburst_g2", 32'(gnt), 32'h4);
        tick();
        req = '0; lock = '0;
        tick(); tick(); tick();

        // Requester 0 writes 44 to 2, requester 1 reads 2 next cycle.
        req = 3'b001; we = 3'b001; a[0] = 6'h02; d[0] = 8'h44; #1;
        check("fw_wgnt", 32'(gnt), 32'h1);
        tick();
        req = 3'b010; we = '0; a[1] = 6'h02; #1;
        check("fw_rgnt", 32'(gnt), 32'h2);
        tick();
        req = '0;
        tick();
        check("fw_rv_early", 32'(rvalid), 32'h0);
        tick();
        check("fw_rv", 32'(rvalid), 32'h2);
        check("fw_rd", 32'(rdata), 32'h44);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing one RAM port.
REQ-002 Parameter AW, default 6: RAM address width (64 words).
REQ-003 Parameter DW, default 8: RAM data width.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive locked transfers granted to one requester.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester access request.
REQ-008 lock  in  NREQ  per-requester burst-hold request, qualified by req.
REQ-009 we  in  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-010 addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
REQ-011 wdata  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
REQ-012 gnt  out  NREQ  one-hot combinational grant.
REQ-013 rvalid  out  NREQ  one-hot read-data-valid strobe.
REQ-014 rdata  out  DW  read data; equals ram_q.
REQ-015 ram_addr  out  AW  registered address to the RAM port.
REQ-016 ram_data  out  DW  registered write data to the RAM port.
REQ-017 ram_we  out  1  registered write enable to the RAM port.
REQ-018 ram_q  in  DW  RAM port output; synchronous, valid one edge after address.

Function
REQ-019 gnt is at most one-hot, zero when req is zero, and only set on a bit whose req is 1.
REQ-020 Transfer accepted at an edge where req[i] & gnt[i] = 1; requester presents next request only after that edge.
REQ-021 Round-robin: search starts at priority pointer ptr and wraps from NREQ-1 to 0; first requesting index wins.
REQ-022 Unlocked accept of i: ptr <= (i+1) mod NREQ, burst count <= 0.
REQ-023 Locked accept of i (lock[i]=1): burst count increments; ptr stays at i while count < MAX_BURST.
REQ-024 On the MAX_BURST-th consecutive locked accept of i: ptr <= (i+1) mod NREQ, count <= 0, even if lock[i] remains 1.
REQ-025 Cycle with no accept: ptr unchanged, burst count <= 0 (gap ends burst).
REQ-026 On accept at edge k, ram_addr/ram_data/ram_we are loaded from the winner's slice; RAM performs the access at edge k+1.
REQ-027 Cycle with no accept: ram_we <= 0; ram_addr and ram_data hold.
REQ-028 Read accepted at edge k: rvalid[i] = 1 for exactly the cycle after edge k+2, with rdata = ram_q (read latency 2 edges).
REQ-029 Writes never assert rvalid.
REQ-030 Back-to-back accepts, one per cycle, are sustained; rvalid pipeline is 2 stages of {valid, index}.
REQ-031 A write to address A accepted at edge k, followed by a read of A accepted at edge k+1, returns the new data.
REQ-032 req dropped without gnt: no effect on ptr or count; request lost, no error.

Reset
REQ-033 When rst = 1 at an edge: ptr <= 0; burst count <= 0; ram_we <= 0; ram_addr <= 0; ram_data <= 0; rvalid pipeline cleared.
REQ-034 While rst = 1, gnt = 0 and no transfer is accepted.
REQ-035 Reads in flight at reset never produce rvalid.

Verification
REQ-036 After reset, req=3'b111, all unlocked: grants go 0, 1, 2, 0 on consecutive edges, one per cycle.
REQ-037 Requester 1 writes 8'h33 to 6'h01 at edge k, then reads 6'h01 at edge k+1: rvalid=3'b010 with rdata=8'h33 after edge k+3.
REQ-038 Requester 0 locked with req held, requester 2 requesting: 4 grants to 0, then 1 to 2, then 0 again.
REQ-039 Requester 2 issues read of 6'h02 and rst asserts at the next edge: no rvalid; gnt=0 during reset; ptr=0 afterward.
REQ-040 Requester 0 writes 8'h44 to 6'h02 and requester 1 reads 6'h02 in the next cycle: requester 1 gets rdata=8'h44.
REQ-041 req=0 for 3 cycles mid-stream: ram_we=0, no rvalid, ptr unchanged; locked requester's burst count restarts at 0.
